// File: rtl/hpf_pkg.sv
// Shared constants and types for the HPF streaming controller: frame phases,
// sample/result width and nibble width.
package hpf_pkg;

  localparam int MAC_TAPS  = 16;
  localparam int FRAME_LEN = 1 + 2 + MAC_TAPS + 1;
  localparam int PH_W      = $clog2(FRAME_LEN);
  localparam int SAMPLE_W  = 8;
  localparam int NIB_W     = 4;

  typedef logic [PH_W-1:0]     ph_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [NIB_W-1:0]    nib_t;

  localparam ph_t PH_WAIT = ph_t'(0);
  localparam ph_t PH_LO   = ph_t'(1);
  localparam ph_t PH_HI   = ph_t'(2);
  localparam ph_t PH_MAC0 = ph_t'(3);
  localparam ph_t PH_OUT  = PH_MAC0 + ph_t'(MAC_TAPS);

  function automatic ph_t next_phase(input ph_t ph);
    return (ph == PH_OUT) ? PH_WAIT : ph + ph_t'(1);
  endfunction

endpackage

// File: rtl/hpf_stream_ctrl_fifo.sv
// Synchronous FIFO with registered occupancy count; reads zero when empty so
// the head output has a defined value straight out of reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count,
  // and a resettable array would cost a reset net per bit for nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hpf_stream_ctrl.sv
// Front/back-end for the free-running 16-tap nibble-serial HPF engine: mirrors
// its 20-cycle frame, feeds sample nibbles and buffers results.
module hpf_stream_ctrl
  import hpf_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [3:0]       x_half,
  input  logic             z_valid,
  input  logic [7:0]       z,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             locked,
  output logic             underrun,
  output logic             overflow,
  output logic             sync_err,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ph_t     ph, ph_d;
  sample_t hold, in_head, fetch_data;
  nib_t    x_half_d;
  logic    in_full, in_empty, in_push, in_pop;
  logic    out_full, out_empty, out_push, out_pop;
  logic    fetch, starve, aligned, misaligned;

  assign in_ready   = !in_full;
  assign in_push    = in_valid && !in_full;
  assign fetch      = (ph == PH_WAIT);
  assign starve     = fetch && in_empty;
  assign in_pop     = fetch && !in_empty;
  assign fetch_data = in_empty ? '0 : in_head;

  assign aligned    = z_valid && (ph == PH_OUT);
  assign misaligned = z_valid && (ph != PH_OUT);

  assign out_valid  = !out_empty;
  assign out_pop    = out_valid && out_ready;
  assign out_push   = z_valid && (!out_full || out_pop);

  sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset),
    .push(in_push), .push_data(in_data),
    .pop(in_pop), .pop_data(in_head),
    .full(in_full), .empty(in_empty)
  );

  sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset),
    .push(out_push), .push_data(z),
    .pop(out_pop), .pop_data(out_data),
    .full(out_full), .empty(out_empty)
  );

  // x_half is loaded one edge ahead so it is stable for the engine's capture
  // cycle; the low nibble comes from the sample being fetched at that edge.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    ph_d     = misaligned ? PH_WAIT : next_phase(ph);
    x_half_d = '0;
    if (ph_d == PH_LO)      x_half_d = fetch_data[NIB_W-1:0];
    else if (ph_d == PH_HI) x_half_d = hold[SAMPLE_W-1:NIB_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph           <= PH_OUT;
      hold         <= '0;
      x_half       <= '0;
      locked       <= 1'b0;
      underrun     <= 1'b0;
      overflow     <= 1'b0;
      sync_err     <= 1'b0;
      underrun_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      ph       <= ph_d;
      x_half   <= x_half_d;
      underrun <= starve;
      overflow <= z_valid && !out_push;
      sync_err <= misaligned;
      if (fetch) hold <= fetch_data;
      if (aligned)         locked <= 1'b1;
      else if (misaligned) locked <= 1'b0;
      if (starve && underrun_cnt != CNT_MAX)
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      if (z_valid && !out_push && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
